// File: rtl/actor_pkg.sv
// actor_pkg: shared types and constants for the actor motion block.
//   dir_t      - movement direction (NONE, UP, DOWN, LEFT, RIGHT)
//   KEY_*      - keyboard scan codes that request a direction
//   wall_ok()  - selects the wall_free bit that belongs to a direction
package actor_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;

  // wall_free layout: [3] up, [2] down, [1] left, [0] right.
  // NONE never counts as free so it can never be "applied".
  function automatic logic wall_ok(input dir_t d, input logic [3:0] wf);
    case (d)
      UP:      wall_ok = wf[3];
      DOWN:    wall_ok = wf[2];
      LEFT:    wall_ok = wf[1];
      RIGHT:   wall_ok = wf[0];
      default: wall_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/actor_motion_if.sv
// actor_motion_if: bundles the game-side inputs and sprite outputs of
// actor_motion.
//   slave  - the motion block (consumes Over/keycode/wall_free/DrawX/DrawY,
//            produces position, velocity, direction and ball_on)
//   master - the game logic / video side driving it
interface actor_motion_if;
  import actor_pkg::*;

  logic       Over;
  logic [7:0] keycode;
  logic [3:0] wall_free;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] Xmotion;
  logic [9:0] Ymotion;
  dir_t       dir;
  dir_t       pending;
  logic       moving;
  logic       tunnel;
  logic       ball_on;

  modport slave (
    input  Over, keycode, wall_free, DrawX, DrawY,
    output BallX, BallY, Xmotion, Ymotion, dir, pending, moving, tunnel, ball_on
  );

  modport master (
    output Over, keycode, wall_free, DrawX, DrawY,
    input  BallX, BallY, Xmotion, Ymotion, dir, pending, moving, tunnel, ball_on
  );

endinterface

// File: rtl/actor_key_dec.sv
// actor_key_dec: maps a keyboard scan code to a direction request.
//   keycode   in  8  current key
//   key_dir   out    decoded direction, NONE for unrecognised codes
//   key_valid out 1  key_dir is a real direction
module actor_key_dec
  import actor_pkg::*;
(
  input  logic [7:0] keycode,
  output dir_t       key_dir,
  output logic       key_valid
);

  always_comb begin
    key_dir = NONE;
    case (keycode)
      KEY_UP:    key_dir = UP;
      KEY_DOWN:  key_dir = DOWN;
      KEY_LEFT:  key_dir = LEFT;
      KEY_RIGHT: key_dir = RIGHT;
      default:   key_dir = NONE;
    endcase
  end

  assign key_valid = (key_dir != NONE);

endmodule

// File: rtl/actor_motion.sv
// actor_motion: grid-style sprite mover with a queued turn, speed divider,
// wall blocking and optional horizontal tunnel wrap.
//   frame_clk in  1  one rising edge per video frame
//   Reset     in  1  asynchronous active-high reset
//   bus       slave modport of actor_motion_if:
//             Over (sync clear), keycode, wall_free, DrawX/DrawY in;
//             BallX/BallY, Xmotion/Ymotion, dir, pending, moving,
//             tunnel (wrap pulse), ball_on (combinational hit) out
module actor_motion
  import actor_pkg::*;
#(
  parameter int STEP      = 1,
  parameter int SIZE      = 16,
  parameter int X_START   = 314,
  parameter int Y_START   = 209,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int SPEED_DIV = 1,
  parameter int PEND_TTL  = 8,
  parameter int TUNNEL_EN = 1
) (
  input  logic          frame_clk,
  input  logic          Reset,
  actor_motion_if.slave bus
);

  localparam logic [9:0] STEP_P   = 10'(STEP);
  localparam logic [9:0] STEP_N   = ~STEP_P + 10'd1;   // -STEP, added instead of subtracting
  localparam logic [9:0] X_INIT   = 10'(X_START);
  localparam logic [9:0] Y_INIT   = 10'(Y_START);
  localparam logic [9:0] X_LO     = 10'(X_MIN);
  localparam logic [9:0] X_HI     = 10'(X_MAX - SIZE + 1);  // left column when touching X_MAX
  localparam logic [3:0] CNT_LAST = 4'(SPEED_DIV - 1);
  localparam logic [7:0] TTL_INIT = 8'(PEND_TTL);

  logic [9:0] ball_x_reg, ball_x_next, ball_y_reg, ball_y_next;
  logic [9:0] xmot_reg, xmot_next, ymot_reg, ymot_next;
  dir_t       dir_reg, dir_next, pend_reg, pend_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [7:0] ttl_reg, ttl_next;
  logic       tunnel_reg, tunnel_next;

  dir_t key_dir, cand, dir_sel;
  logic key_valid, tick;

  actor_key_dec u_key_dec (
    .keycode   (bus.keycode),
    .key_dir   (key_dir),
    .key_valid (key_valid)
  );

  assign tick = (cnt_reg == CNT_LAST);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      ball_x_reg <= X_INIT;
      ball_y_reg <= Y_INIT;
      dir_reg    <= NONE;
      pend_reg   <= NONE;
      cnt_reg    <= '0;
      ttl_reg    <= '0;
      xmot_reg   <= '0;
      ymot_reg   <= '0;
      tunnel_reg <= 1'b0;
    end else begin
      ball_x_reg <= ball_x_next;
      ball_y_reg <= ball_y_next;
      dir_reg    <= dir_next;
      pend_reg   <= pend_next;
      cnt_reg    <= cnt_next;
      ttl_reg    <= ttl_next;
      xmot_reg   <= xmot_next;
      ymot_reg   <= ymot_next;
      tunnel_reg <= tunnel_next;
    end
  end

  always_comb begin
    ball_x_next = ball_x_reg;
    ball_y_next = ball_y_reg;
    dir_next    = dir_reg;
    pend_next   = pend_reg;
    cnt_next    = tick ? 4'd0 : cnt_reg + 4'd1;
    ttl_next    = ttl_reg;
    xmot_next   = xmot_reg;
    ymot_next   = ymot_reg;
    tunnel_next = 1'b0;
    // A key pressed this frame beats whatever was queued earlier.
    cand        = key_valid ? key_dir : pend_reg;
    dir_sel     = dir_reg;

    if (key_valid) begin
      pend_next = key_dir;
      ttl_next  = TTL_INIT;
    end

    if (tick) begin
      if (wall_ok(cand, bus.wall_free)) begin
        dir_sel   = cand;
        pend_next = NONE;
        ttl_next  = '0;
      end else begin
        if (dir_reg != NONE && !wall_ok(dir_reg, bus.wall_free))
          dir_sel = NONE;
        // A freshly loaded request keeps its full lifetime this frame.
        if (!key_valid && pend_reg != NONE && PEND_TTL != 0) begin
          ttl_next = ttl_reg - 8'd1;
          if (ttl_reg == 8'd1)
            pend_next = NONE;
        end
      end

      dir_next = dir_sel;
      case (dir_sel)
        UP:   ball_y_next = ball_y_reg + STEP_N;
        DOWN: ball_y_next = ball_y_reg + STEP_P;
        LEFT: begin
          if (ball_x_reg == X_LO) begin
            if (TUNNEL_EN != 0) begin
              ball_x_next = X_HI;
              tunnel_next = 1'b1;
            end else begin
              dir_next = NONE;
            end
          end else begin
            ball_x_next = ball_x_reg + STEP_N;
          end
        end
        RIGHT: begin
          if (ball_x_reg == X_HI) begin
            if (TUNNEL_EN != 0) begin
              ball_x_next = X_LO;
              tunnel_next = 1'b1;
            end else begin
              dir_next = NONE;
            end
          end else begin
            ball_x_next = ball_x_reg + STEP_P;
          end
        end
        default: ;
      endcase

      // Velocity follows the final direction, so a blocked edge reads 0.
      xmot_next = (dir_next == LEFT)  ? STEP_N :
                  (dir_next == RIGHT) ? STEP_P : 10'd0;
      ymot_next = (dir_next == UP)    ? STEP_N :
                  (dir_next == DOWN)  ? STEP_P : 10'd0;
    end

    if (bus.Over) begin
      ball_x_next = X_INIT;
      ball_y_next = Y_INIT;
      dir_next    = NONE;
      pend_next   = NONE;
      cnt_next    = '0;
      ttl_next    = '0;
      xmot_next   = '0;
      ymot_next   = '0;
      tunnel_next = 1'b0;
    end
  end

  // 11-bit compare so a sprite near column 1023 does not wrap the window.
  logic [10:0] x_lo, x_hi, y_lo, y_hi, px, py;
  assign x_lo = {1'b0, ball_x_reg};
  assign x_hi = x_lo + 11'(SIZE);
  assign y_lo = {1'b0, ball_y_reg};
  assign y_hi = y_lo + 11'(SIZE);
  assign px   = {1'b0, bus.DrawX};
  assign py   = {1'b0, bus.DrawY};

  assign bus.ball_on = (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);
  assign bus.BallX   = ball_x_reg;
  assign bus.BallY   = ball_y_reg;
  assign bus.Xmotion = xmot_reg;
  assign bus.Ymotion = ymot_reg;
  assign bus.dir     = dir_reg;
  assign bus.pending = pend_reg;
  assign bus.moving  = (dir_reg != NONE);
  assign bus.tunnel  = tunnel_reg;

endmodule

// File: doc/actor_motion.md
ACTOR_MOTION -- requirements
Module: actor_motion

Interface
REQ-001 Parameters SHALL be: STEP, default 1, pixels per move; SIZE, 16, sprite edge in pixels; X_START, 314, reset X; Y_START, 209, reset Y; X_MIN, 0, leftmost X; X_MAX, 639, rightmost pixel column; SPEED_DIV, 1, frames per move (1..15); PEND_TTL, 8, moves a queued turn survives (0 = never expires); TUNNEL_EN, 1, horizontal wrap enable.
REQ-002 The design SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-003 frame_clk  in  1  sole clock, one rising edge per video frame.
REQ-004 Reset  in  1  asynchronous active-high reset.
REQ-005 Over  in  1  synchronous game-over clear.
REQ-006 keycode  in  8  current key; 0x1A up, 0x16 down, 0x04 left, 0x07 right; anything else is no request.
REQ-007 wall_free  in  4  move-allowed flags at the current position: [3] up, [2] down, [1] left, [0] right.
REQ-008 DrawX, DrawY  in  10 each  current pixel.
REQ-009 BallX, BallY  out  10 each  sprite top-left corner.
REQ-010 Xmotion, Ymotion  out  10 each  two's-complement velocity: +STEP, -STEP or 0.
REQ-011 dir, pending  out  3 each  dir_t current and queued direction.
REQ-012 moving  out  1  dir != NONE.
REQ-013 tunnel  out  1  one-frame pulse on wrap.
REQ-014 ball_on  out  1  combinational; DrawX in [BallX, BallX+SIZE) and DrawY in [BallY, BallY+SIZE).

Function
REQ-015 A speed counter SHALL count 0..SPEED_DIV-1 on each edge, wrap to 0, and assert tick when it equals SPEED_DIV-1; SPEED_DIV=1 ticks every frame.
REQ-016 On every edge with a valid key, pending SHALL load the decoded direction, overwriting any older request, and the TTL counter SHALL reload to PEND_TTL.
REQ-017 On a tick, candidate = decoded key if valid this edge, else pending.
REQ-018 On a tick, if candidate != NONE and its wall_free bit is 1: dir <= candidate, pending <= NONE.
REQ-019 Otherwise on a tick, if dir != NONE and its wall_free bit is 0: dir <= NONE; pending unchanged.
REQ-020 On a tick, the position SHALL advance by STEP in the resulting direction; no change when it is NONE. wall_free SHALL be the value sampled at the pre-update position.
REQ-021 On a tick with an unapplied pending and PEND_TTL != 0, TTL SHALL decrement; on reaching 0, pending SHALL clear to NONE.
REQ-022 Xmotion/Ymotion SHALL be registered and updated with dir; exactly one axis is non-zero while moving.
REQ-023 If TUNNEL_EN=1, a left move from BallX=X_MIN SHALL set BallX to X_MAX-SIZE+1, and a right move with BallX+SIZE-1=X_MAX SHALL set BallX to X_MIN; tunnel pulses for that frame.
REQ-024 If TUNNEL_EN=0, at those edges dir SHALL become NONE and the position SHALL hold.
REQ-025 All position arithmetic SHALL be 10-bit unsigned; subtraction uses two's-complement add of -STEP.
REQ-026 Between ticks, only the counter, pending and TTL SHALL change.

Reset
REQ-027 Reset SHALL asynchronously set BallX=X_START, BallY=Y_START, dir=pending=NONE, counter=0, TTL=0, Xmotion=Ymotion=0 and tunnel=0.
REQ-028 Over SHALL produce the same values on the next edge, with priority over all other updates; Reset SHALL have priority over Over.
REQ-029 Reset asserted mid-move SHALL drop any queued turn; no partial step SHALL persist.

Structure
REQ-030 Package actor_pkg SHALL hold dir_t (NONE, UP, DOWN, LEFT, RIGHT) and the four keycode constants.
REQ-031 One sub-module, actor_key_dec, SHALL map keycode to dir_t plus a valid bit.

Verification
REQ-032 Reset, wall_free=4'b1111, key 0x07 one frame, SPEED_DIV=1 -> dir=RIGHT; BallX 315, 316, 317 on successive frames; Xmotion=1.
REQ-033 Moving RIGHT, key 0x1A with wall_free[3]=0 -> pending=UP; raise wall_free[3] 3 ticks later -> dir=UP on that tick, Ymotion=10'h3FF, pending=NONE.
REQ-034 PEND_TTL=2, queued UP with wall never free -> pending clears to NONE after 2 ticks; dir unaffected.
REQ-035 BallX=0 moving LEFT, TUNNEL_EN=1 -> BallX=624, tunnel high one frame; same with TUNNEL_EN=0 -> BallX holds at 0, dir=NONE.
REQ-036 SPEED_DIV=3, moving DOWN -> BallY changes every third frame; Over asserted mid-move -> next edge BallX=314, BallY=209, all motion 0.
